// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: prescaled advance strobe, debounced mode/direction buttons,
// mode FSM with generator clear, and registered LED pattern select.
module led_seq_ctrl #(
    parameter int          N_LEDS    = 4,
    parameter int          CNT_W     = 32,
    parameter int unsigned LIM0      = 2**23-1,
    parameter int unsigned LIM1      = 2**22-1,
    parameter int unsigned LIM2      = 2**21-1,
    parameter int unsigned LIM3      = 2**20-1,
    parameter int          DB_CYCLES = 16
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic [1:0]        i_speed,
    input  logic              i_btn_mode,
    input  logic              i_btn_dir,
    input  logic [N_LEDS-1:0] i_pat_shift,
    input  logic [N_LEDS-1:0] i_pat_flash,
    input  logic [N_LEDS-1:0] i_pat_shift2,
    output logic              o_enable,
    output logic              o_dir,
    output logic [1:0]        o_mode,
    output logic              o_clr_n,
    output logic [N_LEDS-1:0] o_leds
);

    localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_FLASH  = 2'd1,
        MODE_SHIFT2 = 2'd2
    } mode_e;

    // Bit 0 is the mode button, bit 1 the direction button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db_lvl;
    logic [1:0]      db_prev;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press;
    logic            mode_press;
    logic            dir_press;

    mode_e             mode_q;
    mode_e             mode_d;
    logic              mode_change;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  lim_sel;
    logic [N_LEDS-1:0] pat_sel;

    assign btn_raw    = {i_btn_dir, i_btn_mode};
    assign press      = db_lvl & ~db_prev;
    assign mode_press = press[0];
    assign dir_press  = press[1];

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db_lvl  <= '0;
            db_prev <= '0;
            for (int b = 0; b < 2; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db_lvl;
            for (int b = 0; b < 2; b++) begin
                if (sync2[b] != db_lvl[b]) begin
                    if (db_cnt[b] == DB_W'(DB_CYCLES-1)) begin
                        db_lvl[b] <= sync2[b];
                        db_cnt[b] <= '0;
                    end else begin
                        db_cnt[b] <= db_cnt[b] + 1'b1;
                    end
                end else begin
                    db_cnt[b] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            mode_q <= MODE_SHIFT;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_press) begin
            case (mode_q)
                MODE_SHIFT:  mode_d = MODE_FLASH;
                MODE_FLASH:  mode_d = MODE_SHIFT2;
                default:     mode_d = MODE_SHIFT;
            endcase
        end
    end

    assign mode_change = (mode_d != mode_q);
    assign o_mode      = mode_q;

    always_comb begin
        lim_sel = CNT_W'(LIM0);
        case (i_speed)
            2'd1:    lim_sel = CNT_W'(LIM1);
            2'd2:    lim_sel = CNT_W'(LIM2);
            2'd3:    lim_sel = CNT_W'(LIM3);
            default: lim_sel = CNT_W'(LIM0);
        endcase
    end

    always_comb begin
        pat_sel = '0;
        case (mode_q)
            MODE_SHIFT:  pat_sel = i_pat_shift;
            MODE_FLASH:  pat_sel = i_pat_flash;
            MODE_SHIFT2: pat_sel = i_pat_shift2;
            default:     pat_sel = '0;
        endcase
    end

    // Greater-or-equal so that a speed switch to a shorter limit ticks promptly.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            count    <= '0;
            o_enable <= 1'b0;
        end else if (mode_change) begin
            count    <= '0;
            o_enable <= 1'b0;
        end else if (i_run) begin
            if (count >= lim_sel) begin
                count    <= '0;
                o_enable <= 1'b1;
            end else begin
                count    <= count + 1'b1;
                o_enable <= 1'b0;
            end
        end else begin
            o_enable <= 1'b0;
        end
    end

    // LEDs stay dark through the clear cycle and the cycle after it, while generators restart.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            o_dir   <= 1'b1;
            o_clr_n <= 1'b1;
            o_leds  <= '0;
        end else begin
            if (dir_press) begin
                o_dir <= ~o_dir;
            end
            o_clr_n <= ~mode_change;
            if (mode_change || !o_clr_n) begin
                o_leds <= '0;
            end else begin
                o_leds <= pat_sel;
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with shortened prescaler limits and debounce time.
module tb_led_seq_ctrl;

    logic       clock;
    logic       i_reset;
    logic       i_run;
    logic [1:0] i_speed;
    logic       i_btn_mode;
    logic       i_btn_dir;
    logic [3:0] i_pat_shift;
    logic [3:0] i_pat_flash;
    logic [3:0] i_pat_shift2;
    logic       o_enable;
    logic       o_dir;
    logic [1:0] o_mode;
    logic       o_clr_n;
    logic [3:0] o_leds;

    int         n_checks = 0;
    int         n_errors = 0;
    int         clr_pulses;
    logic [0:0] exp_q[$];

    led_seq_ctrl #(
        .N_LEDS(4), .CNT_W(8), .LIM0(3), .LIM1(1), .LIM2(2), .LIM3(0), .DB_CYCLES(4)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_run(i_run), .i_speed(i_speed),
        .i_btn_mode(i_btn_mode), .i_btn_dir(i_btn_dir),
        .i_pat_shift(i_pat_shift), .i_pat_flash(i_pat_flash), .i_pat_shift2(i_pat_shift2),
        .o_enable(o_enable), .o_dir(o_dir), .o_mode(o_mode), .o_clr_n(o_clr_n), .o_leds(o_leds)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drains exp_q one cycle at a time against o_enable.
    task automatic run_enable_queue(input string tag);
        while (exp_q.size() > 0) begin
            @(negedge clock);
            check(tag, 32'(o_enable), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic press_mode(input int hold, input int idle);
        i_btn_mode = 1'b1;
        cycles(hold);
        i_btn_mode = 1'b0;
        cycles(idle);
    endtask

    initial begin
        i_reset      = 1'b0;
        i_run        = 1'b1;
        i_speed      = 2'd0;
        i_btn_mode   = 1'b0;
        i_btn_dir    = 1'b0;
        i_pat_shift  = 4'b0110;
        i_pat_flash  = 4'b1001;
        i_pat_shift2 = 4'b0011;
        cycles(3);
        check("rst_enable", 32'(o_enable), 32'd0);
        check("rst_dir",    32'(o_dir),    32'd1);
        check("rst_mode",   32'(o_mode),   32'd0);
        check("rst_clr_n",  32'(o_clr_n),  32'd1);
        check("rst_leds",   32'(o_leds),   32'd0);
        i_reset = 1'b1;

        // Slowest speed: tick every 4th cycle, first on the 4th edge.
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_enable_queue("en_speed0");
        i_speed = 2'd3;
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_enable_queue("en_speed3");

        // Switch to a shorter limit with count=2, then freeze and resume.
        i_speed = 2'd0;
        exp_q = '{1'b0, 1'b0};
        run_enable_queue("en_count_up");
        i_speed = 2'd1;
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        run_enable_queue("en_speed_switch");
        i_run = 1'b0;
        repeat (10) exp_q.push_back(1'b0);
        run_enable_queue("en_frozen");
        i_run = 1'b1;
        exp_q = '{1'b1};
        run_enable_queue("en_resume_held");

        // Mode press: change lands exactly 7 edges after the rise.
        i_speed = 2'd3;
        check("leds_shift", 32'(o_leds), 32'h6);
        i_btn_mode = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            check("mode_before", 32'(o_mode), 32'd0);
            check("clr_before",  32'(o_clr_n), 32'd1);
        end
        @(negedge clock);
        check("mode_change",  32'(o_mode),   32'd1);
        check("clr_pulse",    32'(o_clr_n),  32'd0);
        check("en_forced0",   32'(o_enable), 32'd0);
        check("leds_clr",     32'(o_leds),   32'd0);
        @(negedge clock);
        check("clr_end",      32'(o_clr_n),  32'd1);
        check("leds_after",   32'(o_leds),   32'd0);
        check("en_after_clr", 32'(o_enable), 32'd1);
        @(negedge clock);
        check("leds_flash",   32'(o_leds),   32'h9);
        cycles(11);
        i_btn_mode = 1'b0;
        cycles(10);
        check("mode_release", 32'(o_mode), 32'd1);
        press_mode(8, 10);
        check("mode_shift2",  32'(o_mode), 32'd2);
        check("leds_shift2",  32'(o_leds), 32'h3);
        press_mode(8, 10);
        check("mode_wrap",    32'(o_mode), 32'd0);
        check("leds_wrap",    32'(o_leds), 32'h6);

        // Glitch shorter than the debounce window.
        i_btn_mode = 1'b1;
        cycles(3);
        i_btn_mode = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            check("glitch_mode", 32'(o_mode),  32'd0);
            check("glitch_clr",  32'(o_clr_n), 32'd1);
        end

        // Simultaneous mode and direction presses.
        clr_pulses = 0;
        i_btn_mode = 1'b1;
        i_btn_dir  = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 7) begin
                check("both_mode", 32'(o_mode), 32'd1);
                check("both_dir",  32'(o_dir),  32'd0);
            end
            if (!o_clr_n) clr_pulses++;
        end
        check("both_clr_count", 32'(clr_pulses), 32'd1);
        i_btn_mode = 1'b0;
        i_btn_dir  = 1'b0;
        cycles(10);
        check("leds_flash2", 32'(o_leds), 32'h9);

        // Reset mid-run, with the direction button held through release.
        i_btn_dir = 1'b1;
        @(negedge clock);
        i_reset = 1'b0;
        #1;
        check("midrst_leds",   32'(o_leds),   32'd0);
        check("midrst_mode",   32'(o_mode),   32'd0);
        check("midrst_dir",    32'(o_dir),    32'd1);
        check("midrst_enable", 32'(o_enable), 32'd0);
        @(negedge clock);
        i_pat_shift = 4'b0110;
        i_reset     = 1'b1;
        @(negedge clock);
        check("postrst_leds", 32'(o_leds), 32'h6);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clock);
            if (k == 6) check("held_dir_wait", 32'(o_dir), 32'd1);
            if (k == 7) begin
                check("held_dir_toggle", 32'(o_dir),  32'd0);
                check("held_mode",       32'(o_mode), 32'd0);
            end
        end
        i_btn_dir = 1'b0;
        cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
